core_axi_rd_arbiter: RTL

//  Shares one AXI4-Lite read channel (AR+R) between two core masters: M0 = instruction fetch, M1 = load unit.

---
 rtl/core_axi_rd_arbiter_pkg.sv | 28 ++
 rtl/core_axi_rd_arbiter_if.sv | 31 +++
 rtl/core_axi_rd_arbiter_rr_arb2.sv | 48 ++++
 rtl/core_axi_rd_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/core_axi_rd_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// core_axi_pkg
// Shared definitions for the two-master AXI4-Lite read arbiter:
//   - state_t    : arbiter FSM encoding (IDLE -> ADDR -> DATA -> IDLE)
//   - ARB_*      : arbitration mode constants (fixed priority / round-robin)
//   - GNT_*      : one-hot grant encodings {M1,M0}
//   - RESP_*     : AXI read response codes used by the core
// No ports (package).
// ----------------------------------------------------------------------------
package core_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : core_axi_pkg

// File: rtl/core_axi_rd_arbiter_if.sv
// ----------------------------------------------------------------------------
// core_axi_rd_arbiter_if
// One AXI4-Lite read channel (AR + R).
//   master modport : drives araddr/arvalid/rready, receives arready/rdata/rresp/rvalid
//   slave  modport : the mirror image
// Parameters: AW = address width, DW = data width.
// ----------------------------------------------------------------------------
interface core_axi_rd_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 32
) ();

    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface : core_axi_rd_arbiter_if

// File: rtl/core_axi_rd_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// core_rr_arb2
// Two-way request -> one-hot grant selector with a last-grant register.
//   CLK, NRST : clock, synchronous active-low reset
//   mode      : ARB_FIXED (M1 beats M0) or ARB_RR (alternate on contention)
//   req       : {M1,M0} requests
//   upd       : load last-grant from upd_gnt (end of a transaction)
//   upd_gnt   : grant of the transaction that just completed
//   gnt       : combinational one-hot winner, 00 when nobody requests
// ----------------------------------------------------------------------------
module core_rr_arb2
    import core_axi_pkg::*;
(
    input  logic       CLK,
    input  logic       NRST,
    input  logic       mode,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic [1:0] upd_gnt,
    output logic [1:0] gnt
);

    // Resets to "M1 was last", so M0 wins the first round-robin tie.
    logic last_m1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            last_m1 <= 1'b1;
        end else if (upd) begin
            last_m1 <= upd_gnt[1];
        end
    end

    // NOTE: default assignment first so no path through the case leaves
    // gnt unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = GNT_NONE;
        case (req)
            2'b01:   gnt = GNT_M0;
            2'b10:   gnt = GNT_M1;
            2'b11:   gnt = (mode == ARB_RR && last_m1) ? GNT_M0 : GNT_M1;
            default: gnt = GNT_NONE;
        endcase
    end

endmodule : core_rr_arb2

// File: rtl/core_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// core_axi_rd_arbiter
// Shares one AXI4-Lite read channel between instruction fetch (M0) and the
// load unit (M1). One transaction outstanding at a time; R data is routed
// back to the granted master only.
//   CLK, NRST : clock, synchronous active-low reset
//   m0, m1    : master-side read channels (arbiter acts as their slave)
//   s         : slave-side read channel toward the interconnect
//   GNT       : one-hot current grant {M1,M0}, 00 when idle
// Parameters: AXI_AWIDTH, AXI_DWIDTH (pass-through widths), ARB_MODE
//   (0 = fixed priority M1 > M0, 1 = round-robin).
// ----------------------------------------------------------------------------
module core_axi_rd_arbiter
    import core_axi_pkg::*;
#(
    parameter int AXI_AWIDTH = 4,
    parameter int AXI_DWIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input  logic                 CLK,
    input  logic                 NRST,
    core_axi_rd_arbiter_if.slave  m0,
    core_axi_rd_arbiter_if.slave  m1,
    core_axi_rd_arbiter_if.master s,
    output logic [1:0]           GNT
);

    state_t                state;
    logic [AXI_AWIDTH-1:0] ar_addr;
    logic                  ar_valid;
    logic [1:0]            req;
    logic [1:0]            win;
    logic                  in_idle;
    logic                  in_data;
    logic                  r_done;

    assign req     = {m1.arvalid, m0.arvalid};
    // ARREADY is a combinational pulse in IDLE; gating with NRST keeps it
    // quiet while reset is held.
    assign in_idle = NRST && (state == ST_IDLE);
    assign in_data = (state == ST_DATA);
    assign r_done  = in_data && s.rvalid && s.rready;

    core_rr_arb2 u_arb (
        .CLK     (CLK),
        .NRST    (NRST),
        .mode    ((ARB_MODE != 0) ? ARB_RR : ARB_FIXED),
        .req     (req),
        .upd     (r_done),
        .upd_gnt (GNT),
        .gnt     (win)
    );

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state    <= ST_IDLE;
            GNT      <= GNT_NONE;
            ar_addr  <= '0;
            ar_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        ar_addr  <= win[1] ? m1.araddr : m0.araddr;
                        ar_valid <= 1'b1;
                        GNT      <= win;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // ar_valid is always 1 here; address held until accepted.
                    if (s.arready) begin
                        ar_valid <= 1'b0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_done) begin
                        GNT   <= GNT_NONE;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Slave address channel.
    assign s.araddr  = ar_addr;
    assign s.arvalid = ar_valid;

    // Address acceptance pulses to the winning master only.
    assign m0.arready = in_idle && win[0];
    assign m1.arready = in_idle && win[1];

    // Data routing; a stray slave RVALID outside DATA is neither forwarded
    // nor consumed.
    assign m0.rvalid  = in_data && GNT[0] && s.rvalid;
    assign m1.rvalid  = in_data && GNT[1] && s.rvalid;
    assign m0.rdata   = s.rdata;
    assign m1.rdata   = s.rdata;
    assign m0.rresp   = s.rresp;
    assign m1.rresp   = s.rresp;
    assign s.rready   = in_data && |(GNT & {m1.rready, m0.rready});

endmodule : core_axi_rd_arbiter
